// File: rtl/dev_tx_arbiter.sv
// Round-robin arbiter owning all pushes into the UART tx pipe; lockable multi-byte bursts.
// Grant one cycle after req, push the next cycle; at most one push per 2 cycles, holds in SEND while tx_full.
module dev_tx_arbiter #(
  parameter int N_REQ     = 2,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16,
  localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        lock,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ack,
  output logic                    grant_valid,
  output logic [ID_W-1:0]         grant_id,
  input  logic                    tx_full,
  output logic                    tx_push_back,
  output logic [DATA_W-1:0]       tx_data_in
);

  localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [7:0]        burst_q, burst_d;
  logic              grant_valid_d, push_d;
  logic [ID_W-1:0]   grant_id_d;
  logic [N_REQ-1:0]  ack_d;
  logic [DATA_W-1:0] data_d;

  logic [DATA_W-1:0] req_byte [N_REQ];
  logic              rr_found;
  logic [ID_W-1:0]   rr_id, rr_cand;
  int                rr_idx;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) req_byte[i] = req_data[i*DATA_W +: DATA_W];
  end

  // First requesting index after the previous owner, wrapping modulo N_REQ.
  always_comb begin
    rr_found = 1'b0;
    rr_id    = '0;
    rr_idx   = 0;
    rr_cand  = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      rr_idx  = (int'(last_grant_q) + off) % N_REQ;
      rr_cand = ID_W'(rr_idx);
      if (!rr_found && req[rr_cand]) begin
        rr_found = 1'b1;
        rr_id    = rr_cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    burst_d       = burst_q;
    grant_valid_d = grant_valid;
    grant_id_d    = grant_id;
    data_d        = tx_data_in;
    push_d        = 1'b0;
    ack_d         = '0;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          grant_id_d    = rr_id;
          grant_valid_d = 1'b1;
          burst_d       = '0;
          state_d       = SEND;
        end
      end
      SEND: begin
        if (req[grant_id]) begin
          if (!tx_full) begin
            data_d          = req_byte[grant_id];
            push_d          = 1'b1;
            ack_d[grant_id] = 1'b1;
            if (burst_q < BURST_LIMIT) burst_d = burst_q + 8'd1;
            state_d         = GAP;
          end
        end else if (!lock[grant_id]) begin
          last_grant_d  = grant_id;
          grant_valid_d = 1'b0;
          state_d       = IDLE;
        end
      end
      GAP: begin
        // req is not looked at here: the requester is still reacting to the ack.
        if (lock[grant_id] && (burst_q < BURST_LIMIT)) begin
          state_d = SEND;
        end else begin
          last_grant_d  = grant_id;
          grant_valid_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(N_REQ - 1);
      burst_q      <= '0;
      grant_valid  <= 1'b0;
      grant_id     <= '0;
      tx_push_back <= 1'b0;
      req_ack      <= '0;
      tx_data_in   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      burst_q      <= burst_d;
      grant_valid  <= grant_valid_d;
      grant_id     <= grant_id_d;
      tx_push_back <= push_d;
      req_ack      <= ack_d;
      tx_data_in   <= data_d;
    end
  end

endmodule

// File: doc/dev_tx_arbiter.md
# dev_tx_arbiter

Shares the single UART transmit pipe (`dev_tx_pipe`) between several byte producers, such as the control unit's `putc` path and the loader's echo path. It replaces the static `cu_tx` multiplexer with round-robin arbitration. A requester can lock the channel so that a multi-byte message is not interleaved with another requester's bytes. The block sits between the requesters and the `tx_pipe` push/full interface, and owns all pushes into that pipe.

## Interface
- `N_REQ`, default 2: number of requesters; index 0 is the highest priority after reset.
- `DATA_W`, default 8: byte width, equal to `pkg_ram::RAM_BYTE`.
- `MAX_BURST`, default 16: maximum bytes per grant while locked; range 1..255.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester byte-valid; held until acked.
- `lock`  in  N_REQ  per-requester request to keep the grant after the current byte.
- `req_data`  in  N_REQ*DATA_W  packed bytes; requester i occupies `[i*DATA_W +: DATA_W]`.
- `req_ack`  out  N_REQ  one-cycle pulse; the byte of requester i was pushed.
- `grant_valid`  out  1  a requester currently owns the channel.
- `grant_id`  out  $clog2(N_REQ) (minimum 1)  owner index, valid when `grant_valid` is high.
- `tx_full`  in  1  `tx_pipe.full`.
- `tx_push_back`  out  1  `tx_pipe.push_back`, a one-cycle pulse.
- `tx_data_in`  out  DATA_W  `tx_pipe.data_in`; stable in the push cycle.

## Operation
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - If any `req` bit is high, search round-robin starting at `last_grant+1` modulo N_REQ.
  - Register the first requester found into `grant_id`, set `grant_valid`, clear `burst_cnt`, and go to SEND.
- SEND:
  - If `req[grant_id]` is high and `!tx_full`: register `tx_data_in <= req_data[grant_id]`, pulse `tx_push_back` and `req_ack[grant_id]`, increment `burst_cnt`, and go to GAP.
  - If `req[grant_id]` is high and `tx_full`: stay in SEND and wait.
  - If `req[grant_id]` is low and `lock[grant_id]` is high: stay in SEND and wait for the next byte.
  - If `req[grant_id]` is low and `lock[grant_id]` is low: release and go to IDLE.
- GAP (the ack cycle, which lets `tx_full` and the requester's `req` update):
  - If `lock[grant_id]` is high and `burst_cnt < MAX_BURST`: go to SEND.
  - Otherwise release: `last_grant <= grant_id`, clear `grant_valid`, go to IDLE.
- Release from SEND (because `req` and `lock` are both low) also sets `last_grant <= grant_id`.
- `burst_cnt` is 8 bits wide and saturates at MAX_BURST. It resets only when a new grant is issued.
- Requesters not granted see no ack. Their `req` and `req_data` must stay stable until they are acked.
- No byte is ever pushed while `tx_full` is high. At most one push happens every 2 cycles.

## Timing
- Reset values:
  - `tx_push_back`, `req_ack`, `grant_valid`, `grant_id`, `tx_data_in` = 0.
  - State = IDLE, `burst_cnt` = 0.
  - `last_grant` = N_REQ-1, so requester 0 wins the first arbitration.
- Latency: `req` goes high before edge k while the FSM is IDLE. `grant_valid` is high after edge k. `tx_push_back` and `req_ack` are high for exactly the one cycle after edge k+1.
- Locked streaming: one byte every 2 cycles (SEND, GAP) while `req` stays high and `tx_full` stays low.
- Handshake:
  - The requester samples `req_ack` high, then presents the next byte, or deasserts `req`, at the following edge.
  - The block does not sample `req` in GAP, so a stale `req` during the ack cycle is harmless.
- Simultaneous requests in IDLE: the round-robin order decides. Only one grant is issued per IDLE visit.
- `tx_full` asserting in the push cycle itself does not cancel that push, because `full` was sampled low in SEND.
- Reset asserted mid-operation: all outputs clear immediately, with no partial pulse. The interrupted requester gets no ack and re-requests after reset.
- `lock` raised by a non-owner has no effect until that requester wins arbitration.

## Test plan
- After reset, `req`=2'b11 with bytes 0x41/0x42 and no lock: pushes occur in the order 0x41 (id 0), then 0x42 (id 1). Each `req_ack` pulse is 1 cycle, and the first push comes 2 cycles after `req`.
- Requester 1 locked with a 3-byte string "abc" while requester 0 also requests 0x30: the pushes are a, b, c, then 0x30, with no interleaving and 2 cycles per locked byte.
- MAX_BURST=4, requester 0 locked with 10 bytes while requester 1 waits: 4 bytes from 0, then 1 byte from 1, then 4 more from 0.
- `tx_full` held high for 20 cycles while requester 0 has 0x55 pending: no push and no ack during that time. The push of 0x55 occurs in the cycle after SEND sees `tx_full` low.
- Locked owner drops `req` for 5 cycles while keeping `lock` high: the grant holds with no pushes. Dropping `lock` then returns the FSM to IDLE and `grant_valid` goes to 0.
- `rst_n` pulsed low in the SEND cycle with 0x7E pending: `tx_push_back` stays 0 and all outputs clear. After release, requester 0 wins and 0x7E is pushed once.
